// File: rtl/timer_ctrl_if.sv
// Port bundle between the kitchen-timer controller and its time base, buttons and display mux.
interface timer_ctrl_if;
   logic       EN1HZ;
   logic       SIG2HZ;
   logic       BTN_START;
   logic       BTN_MIN;
   logic       BTN_SEC;
   logic       BTN_CLR;
   logic [7:0] MIN_BCD;
   logic [7:0] SEC_BCD;
   logic [1:0] STATE;
   logic       BLANK;
   logic       BUZZ;

   modport master (
      output EN1HZ, SIG2HZ, BTN_START, BTN_MIN, BTN_SEC, BTN_CLR,
      input  MIN_BCD, SEC_BCD, STATE, BLANK, BUZZ
   );

   modport slave (
      input  EN1HZ, SIG2HZ, BTN_START, BTN_MIN, BTN_SEC, BTN_CLR,
      output MIN_BCD, SEC_BCD, STATE, BLANK, BUZZ
   );
endinterface

// File: rtl/timer_ctrl.sv
// Countdown kitchen-timer controller: MM:SS set/run/pause/alarm sequencing with BCD outputs,
// pause blink and alarm buzzer, driven by the 1 Hz enable and 2 Hz square wave.
module timer_ctrl #(
   parameter int unsigned MAX_MIN   = 59,
   parameter int unsigned ALARM_SEC = 10
) (
   input logic         CLK,
   input logic         RST,
   timer_ctrl_if.slave bus
);
   localparam int unsigned BCD_W = 8;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned BTN_W = 4;
   localparam logic [BCD_W-1:0] MAX_MIN_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
   localparam logic [BCD_W-1:0] SEC_TOP     = 8'h59;
   localparam logic [CNT_W-1:0] ALARM_TOP   = CNT_W'(ALARM_SEC);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_ALARM = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [BCD_W-1:0]   min_q, min_d;
   logic [BCD_W-1:0]   sec_q, sec_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               blank_q, blank_d;
   logic               buzz_q, buzz_d;
   logic [BTN_W-1:0]   btn_prev_q;
   logic [BTN_W-1:0]   btn_c;
   logic [BTN_W-1:0]   press_c;
   logic               p_clr_c, p_start_c, p_min_c, p_sec_c;

   function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
      bcd_inc = (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] v);
      bcd_dec = (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
   endfunction

   // Rising-edge detect; bit order {clr, start, min, sec}
   assign btn_c     = {bus.BTN_CLR, bus.BTN_START, bus.BTN_MIN, bus.BTN_SEC};
   assign press_c   = btn_c & ~btn_prev_q;
   assign p_clr_c   = press_c[3];
   assign p_start_c = press_c[2];
   assign p_min_c   = press_c[1];
   assign p_sec_c   = press_c[0];

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         min_q      <= '0;
         sec_q      <= '0;
         cnt_q      <= '0;
         blank_q    <= 1'b0;
         buzz_q     <= 1'b0;
         btn_prev_q <= '0;
      end else begin
         state_q    <= state_d;
         min_q      <= min_d;
         sec_q      <= sec_d;
         cnt_q      <= cnt_d;
         blank_q    <= blank_d;
         buzz_q     <= buzz_d;
         btn_prev_q <= btn_c;
      end
   end

   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      sec_d   = sec_q;
      cnt_d   = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (p_clr_c) begin
               min_d = '0;
               sec_d = '0;
            end else if (p_start_c) begin
               if ((min_q != '0) || (sec_q != '0)) state_d = S_RUN;
            end else if (p_min_c) begin
               min_d = (min_q == MAX_MIN_BCD) ? '0 : bcd_inc(min_q);
            end else if (p_sec_c) begin
               sec_d = (sec_q == SEC_TOP) ? '0 : bcd_inc(sec_q);
            end
         end
         S_RUN: begin
            if (p_clr_c) begin
               state_d = S_IDLE;
               min_d   = '0;
               sec_d   = '0;
            end else begin
               if (bus.EN1HZ) begin
                  if (sec_q != '0) begin
                     sec_d = bcd_dec(sec_q);
                  end else begin
                     min_d = bcd_dec(min_q);
                     sec_d = SEC_TOP;
                  end
               end
               if (p_start_c) state_d = S_PAUSE;
               // Reaching zero overrides a same-cycle pause request
               if (bus.EN1HZ && (min_d == '0) && (sec_d == '0)) begin
                  state_d = S_ALARM;
                  cnt_d   = '0;
               end
            end
         end
         S_PAUSE: begin
            if (p_clr_c) begin
               state_d = S_IDLE;
               min_d   = '0;
               sec_d   = '0;
            end else if (p_start_c) begin
               state_d = S_RUN;
            end
         end
         S_ALARM: begin
            if (press_c != '0) begin
               state_d = S_IDLE;
            end else if (bus.EN1HZ) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_d == ALARM_TOP) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      blank_d = (state_d == S_PAUSE) && !bus.SIG2HZ;
      buzz_d  = (state_d == S_ALARM) && bus.SIG2HZ;
   end

   assign bus.MIN_BCD = min_q;
   assign bus.SEC_BCD = sec_q;
   assign bus.STATE   = state_q;
   assign bus.BLANK   = blank_q;
   assign bus.BUZZ    = buzz_q;
endmodule
